// File: rtl/decoder_pkg.sv
// =====================================================================
// decoder_pkg: state and mode encodings shared by the decoder_stream slice
// Rev 1.0
// =====================================================================
`default_nettype none

package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_SCAN = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // The reserved encoding parks the block exactly like OFF.
  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_DEC:            return DEC;
      MODE_SCAN:           return SCAN;
      MODE_OFF, MODE_RSVD: return IDLE;
      default:             return IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decode.sv
// =====================================================================
// onehot_decode: combinational N-bit index to 2**N one-hot word
// Rev 1.0
// =====================================================================
`default_nettype none

module onehot_decode #(
  parameter  int N     = 3,
  localparam int OUT_W = 2 ** N
) (
  input  logic [N-1:0]     in,
  output logic [OUT_W-1:0] out
);

  assign out = OUT_W'(1) << in;

endmodule

`default_nettype wire

// File: rtl/decoder_stream.sv
// =====================================================================
// decoder_stream: registered one-hot decoder stream with self-running SCAN
// Rev 1.0
// =====================================================================
`default_nettype none

module decoder_stream
  import decoder_pkg::*;
#(
  parameter  int N     = 3,
  localparam int OUT_W = 2 ** N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic [N-1:0]     idx,
  output logic             wrap
);

  state_t           state;
  state_t           state_nx;
  logic [N-1:0]     count;
  logic [N-1:0]     sel;
  logic [OUT_W-1:0] sel_onehot;
  logic             slot_free;
  logic             in_fire;
  logic             scan_load;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == DEC) && slot_free;
  assign in_fire   = in_valid && in_ready;
  assign state_nx  = mode_to_state(mode);

  // A scan word is only produced while both the current and the sampled
  // next state are SCAN, so the entry edge itself yields a one-cycle gap.
  assign scan_load = (state == SCAN) && (state_nx == SCAN) && slot_free;

  // count holds the index of the next scan word to emit.
  assign sel = (state == SCAN) ? count : in;

  onehot_decode #(.N(N)) u_onehot_decode (
    .in  (sel),
    .out (sel_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      idx       <= '0;
      wrap      <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
    end else if (slot_free) begin
      state <= state_nx;

      if (in_fire || scan_load) begin
        out       <= sel_onehot;
        idx       <= sel;
        wrap      <= scan_load && (&count);
        out_valid <= 1'b1;
      end else if (state_nx == IDLE) begin
        out       <= '0;
        idx       <= '0;
        wrap      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        // Drain: out and idx keep the last word for the consumer's benefit.
        wrap      <= 1'b0;
        out_valid <= 1'b0;
      end

      if (scan_load) begin
        count <= count + N'(1);
      end else if ((state != SCAN) && (state_nx == SCAN)) begin
        count <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_stream.sv
// =====================================================================
// tb_decoder_stream: directed stimulus with a transaction-level scoreboard
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_decoder_stream;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;

  logic [1:0]  mode_p;
  logic        ready_p;
  logic        p1_in_ready, p1_out_valid, p1_wrap;
  logic [1:0]  p1_out;
  logic [0:0]  p1_idx;
  logic        p6_in_ready, p6_out_valid, p6_wrap;
  logic [63:0] p6_out;
  logic [5:0]  p6_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int scan_epoch = 0;

  always #5 clk = ~clk;

  decoder_stream #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .idx(idx), .wrap(wrap)
  );

  decoder_stream #(.N(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .mode(mode_p),
    .in_valid(1'b0), .in_ready(p1_in_ready), .in(1'b0),
    .out_valid(p1_out_valid), .out_ready(ready_p),
    .out(p1_out), .idx(p1_idx), .wrap(p1_wrap)
  );

  decoder_stream #(.N(6)) dut_n6 (
    .clk(clk), .rst_n(rst_n), .mode(mode_p),
    .in_valid(1'b0), .in_ready(p6_in_ready), .in(6'd0),
    .out_valid(p6_out_valid), .out_ready(ready_p),
    .out(p6_out), .idx(p6_idx), .wrap(p6_wrap)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: decoded words leave in the order their indices were
  // accepted; with no decoded word owed, an accepted word must be the
  // next element of the walking-one sequence.
  int          exp_q[$];
  int          scan_next  = 0;
  int          epoch_seen = 0;
  logic        have_prev  = 1'b0;
  logic        prev_stall;
  logic [12:0] prev_bundle;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      scan_next = 0;
      have_prev = 1'b0;
    end else begin
      if (epoch_seen != scan_epoch) begin
        epoch_seen = scan_epoch;
        scan_next  = 0;
      end
      if (out_valid)
        check("onehot", 64'(out), 64'(1) << idx);
      if (have_prev && prev_stall)
        check("stall_hold", 64'({out_valid, wrap, idx, out}), 64'(prev_bundle));
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          int e;
          e = exp_q.pop_front();
          check("dec_idx", 64'(idx), 64'(e));
          check("dec_out", 64'(out), 64'(1) << e);
          check("dec_wrap", 64'(wrap), 64'(0));
        end else begin
          check("scan_idx", 64'(idx), 64'(scan_next));
          check("scan_wrap", 64'(wrap), 64'(scan_next == 7));
          scan_next = (scan_next + 1) % 8;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(int'(din));
      prev_stall  = out_valid && !out_ready;
      prev_bundle = {out_valid, wrap, idx, out};
      have_prev   = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0; mode = MODE_OFF; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    mode_p = MODE_OFF; ready_p = 1'b1;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_out", 64'(out), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    tick();
    check("post_rst_idx", 64'(idx), 64'(0));
    check("post_rst_wrap", 64'(wrap), 64'(0));
    check("idle_in_ready", 64'(in_ready), 64'(0));
    mode = MODE_DEC;
    tick();
    check("dec_in_ready", 64'(in_ready), 64'(1));

    // Back-to-back decode of 0..7 with no bubbles.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 3'(i); in_valid = 1'b1;
      tick();
      check("sweep_out", 64'(out), 64'(1) << i);
      check("sweep_idx", 64'(idx), 64'(i));
      check("sweep_valid", 64'(out_valid), 64'(1));
      check("sweep_wrap", 64'(wrap), 64'(0));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'(0));
    check("drain_out_hold", 64'(out), 64'h80);
    check("drain_idx_hold", 64'(idx), 64'(7));

    // Backpressure with a waiting index.
    din = 3'd5; in_valid = 1'b1;
    tick();
    check("bp_first", 64'(out), 64'h20);
    out_ready = 1'b0; din = 3'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_out", 64'(out), 64'h20);
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check("bp_replace", 64'(out), 64'h04);
    check("bp_replace_idx", 64'(idx), 64'(2));
    in_valid = 1'b0;
    tick();

    // Walking one with wrap-around.
    mode = MODE_SCAN; scan_epoch++;
    tick();
    check("scan_entry_gap", 64'(out_valid), 64'(0));
    for (int k = 0; k < 12; k++) begin
      tick();
      check("scan_seq_out", 64'(out), 64'(1) << (k % 8));
      check("scan_seq_wrap", 64'(wrap), 64'((k % 8) == 7));
      check("scan_seq_valid", 64'(out_valid), 64'(1));
    end

    // Mode change while the idx=3 word is stalled.
    out_ready = 1'b0; mode = MODE_DEC;
    repeat (3) begin
      tick();
      check("sw_hold_out", 64'(out), 64'h08);
      check("sw_hold_idx", 64'(idx), 64'(3));
      check("sw_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check("sw_after_valid", 64'(out_valid), 64'(0));
    check("sw_after_in_ready", 64'(in_ready), 64'(1));

    // OFF clears the output once the pending word is taken.
    din = 3'd6; in_valid = 1'b1;
    tick();
    check("off_pending", 64'(out), 64'h40);
    mode = MODE_OFF; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("off_stall_out", 64'(out), 64'h40);
    check("off_stall_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick();
    check("off_clear_out", 64'(out), 64'(0));
    check("off_clear_valid", 64'(out_valid), 64'(0));
    check("off_in_ready", 64'(in_ready), 64'(0));

    // Reset with a word pending discards it.
    mode = MODE_DEC;
    tick();
    din = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    check("pend_out", 64'(out), 64'h08);
    rst_n = 1'b0;
    #2;
    check("async_rst_out", 64'(out), 64'(0));
    check("async_rst_valid", 64'(out_valid), 64'(0));
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("discard_valid", 64'(out_valid), 64'(0));
    end

    // N=1 and N=6 walking one over 2**N+1 words.
    mode_p = MODE_SCAN;
    tick();
    check("p6_entry_gap", 64'(p6_out_valid), 64'(0));
    for (int k = 0; k <= 64; k++) begin
      tick();
      check("p6_out", p6_out, 64'(1) << (k % 64));
      check("p6_wrap", 64'(p6_wrap), 64'((k % 64) == 63));
      if (k <= 2) begin
        check("p1_out", 64'(p1_out), 64'(1) << (k % 2));
        check("p1_wrap", 64'(p1_wrap), 64'((k % 2) == 1));
      end
    end
    check("p6_last_idx", 64'(p6_idx), 64'(0));
    rst_n = 1'b0;
    #2;
    check("p6_async_rst", p6_out, 64'(0));
    check("p6_async_valid", 64'(p6_out_valid), 64'(0));
    check("p1_async_rst", 64'(p1_out), 64'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
- Parametrised, registered successor to the combinational 3-to-8 decoder.
- Converts an N-bit index into a 2**N one-hot word over a valid/ready stream, with one output register stage.
- Adds a self-running SCAN mode: a walking-one sequence with a wrap flag, used for LED/row scanning and test-pattern generation.
- Sits between a control FSM or counter and one-hot consumers (mux selects, display rows).

Parameters:
- N, 3, index width; legal range 1..6.
- OUT_W, 2**N, one-hot output width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  00 OFF, 01 DECODE, 10 SCAN, 11 reserved (treated as OFF).
- in_valid  in  1  input index valid.
- in_ready  out  1  block accepts the input index this cycle.
- in  in  N  index to decode.
- out_valid  out  1  out/idx/wrap valid.
- out_ready  in  1  consumer accepts the output.
- out  out  OUT_W  one-hot word, bit idx set.
- idx  out  N  binary index matching out.
- wrap  out  1  set on the SCAN word with idx = OUT_W-1.

Behaviour:
- Reset (rst_n low, async)
  - state=IDLE; out=0, idx=0, wrap=0, out_valid=0, scan count=0.
  - in_ready=0 while rst_n is low.
  - Reset mid-transfer discards the pending word; no output is produced for it.
- Terms
  - "Slot free" = !out_valid || out_ready.
  - A handshake occurs when valid && ready on a port.
- States: IDLE, DEC, SCAN. Transitions are evaluated only on a cycle where the slot is free.
  - State changes on a clock edge driven by the mode value sampled at that edge.
  - OFF or 11: go to IDLE. 01: go to DEC. 10: go to SCAN.
  - If mode changes while out_valid=1 and out_ready=0, the state holds and out/idx/wrap stay stable until the word is accepted.
- IDLE
  - in_ready=0.
  - After the last pending word is accepted, out_valid=0 and out is cleared to 0.
- DEC
  - in_ready = slot free (combinational).
  - Input handshake at edge k: at edge k+1, out=1<<in, idx=in, wrap=0, out_valid=1. Latency is 1 cycle.
  - Full throughput (1 word per cycle) while out_ready=1.
  - Output handshake with no input handshake: out_valid drops to 0; out and idx hold their last value.
  - Simultaneous output and input handshake: the register is replaced with the new word, with no bubble.
- SCAN
  - in_ready=0; in and in_valid are ignored.
  - Entry: the count is forced to 0; the first word appears 1 cycle after entry (out=1, idx=0, out_valid=1).
  - Each output handshake: count = (count+1) mod OUT_W; the next word appears the following cycle, so out_valid stays high.
  - wrap=1 exactly while idx=OUT_W-1. The sequence after OUT_W-1 is 0 (wrap-around).
  - Backpressure freezes the count and the output.
- Invariants
  - out is always one-hot or all-zero.
  - out is all-zero only when out_valid=0.
  - idx always equals log2(out) when out_valid=1.
- Edge case: N=1 gives OUT_W=2; the wrap pattern toggles every accepted word.

Decomposition:
- decoder_pkg:
  - state enum (IDLE, DEC, SCAN).
  - mode constants MODE_OFF, MODE_DEC, MODE_SCAN.
- Sub-module onehot_decode:
  - combinational, parameter N;
  - in[N-1:0] -> out[2**N-1:0] = 1<<in.
  - Instantiated once and fed by a mux of the input index and the scan count.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> out=0, out_valid=0, in_ready=0; after mode=01 and 1 cycle, in_ready=1.
- DEC sweep: N=3, mode=01, out_ready=1, in=0..7 on consecutive cycles -> out=8'b1<<i on cycle i+1, idx=i, no bubbles, wrap=0 throughout.
- Backpressure: in=5 accepted, out_ready=0 for 4 cycles -> out=8'h20 held, in_ready=0; out_ready=1 with in=2 on the same cycle -> next cycle out=8'h04.
- SCAN wrap: mode=10, out_ready=1 for 10 cycles -> out sequence 01,02,04,...,80,01,02; wrap=1 only on 80.
- Mode switch under stall: SCAN at idx=3, out_ready=0, mode set to 01 -> out=8'h08 stays stable; after acceptance, state=DEC and in_ready=1.
- Parameter: N=1 and N=6 builds, SCAN for 2**N+1 words -> each word one-hot, wrap on the last, then idx=0; async reset asserted mid-scan clears out within the same cycle.
